// File: rtl/multicycle_main_controller_pkg.sv
// Shared control encodings for the multicycle MIPS controller: opcodes, select codes, states, trap causes.
// state_ctrl() is the per-state control word, so every Moore output lives in one table.
package multicycle_main_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_ALUWB   = 4'd8,
    S_BEQ     = 4'd9,
    S_ADDI_EX = 4'd10,
    S_LUI_EX  = 4'd11,
    S_IMMWB   = 4'd12,
    S_JUMP    = 4'd13,
    S_JR      = 4'd14,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] FN_JR     = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       dm_we;
    logic       fetch_upd;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       rf_we;
    logic       m_to_rf;
    logic       rfd_sel;
    logic       done;
    logic       done_on_rdy;
    logic       trap;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch_upd = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.rf_we   = 1'b1;
        c.m_to_rf = 1'b1;
        c.done    = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req     = 1'b1;
        c.iord        = 1'b1;
        c.dm_we       = 1'b1;
        c.done_on_rdy = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.rf_we   = 1'b1;
        c.rfd_sel = 1'b1;
        c.done    = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
        c.pc_src    = PCSRC_ALUOUT;
        c.done      = 1'b1;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_LUI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_LUI;
      end
      S_IMMWB: begin
        c.rf_we = 1'b1;
        c.done  = 1'b1;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
        c.done     = 1'b1;
      end
      S_JR: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_RS;
        c.done     = 1'b1;
      end
      S_TRAP: c.trap = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Controller <-> datapath/memory bundle: instruction fields and memory ready in, all selects/enables out.
interface multicycle_main_controller_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] Instruction;
  logic [OP_W-1:0] Function;
  logic            MEM_READY;
  logic            MEM_REQ;
  logic            IorD;
  logic            DM_WRITE_ENABLE;
  logic            IRWrite;
  logic            PCWrite;
  logic            Branch;
  logic [1:0]      PCSrc;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic            RF_WRITE_ENABLE;
  logic            MtoRFSEL;
  logic            RFDSel;
  logic            INSTR_DONE;
  logic            TRAP;
  logic [1:0]      TRAP_CAUSE;

  modport master (
    input  Instruction, Function, MEM_READY,
    output MEM_REQ, IorD, DM_WRITE_ENABLE, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUOp, RF_WRITE_ENABLE, MtoRFSEL, RFDSel,
           INSTR_DONE, TRAP, TRAP_CAUSE
  );

  modport slave (
    output Instruction, Function, MEM_READY,
    input  MEM_REQ, IorD, DM_WRITE_ENABLE, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUOp, RF_WRITE_ENABLE, MtoRFSEL, RFDSel,
           INSTR_DONE, TRAP, TRAP_CAUSE
  );
endinterface

// File: rtl/multicycle_main_controller_mem_wait_timer.sv
// Counts consecutive stalled request cycles; flags a timeout once MEM_TIMEOUT stalls have already elapsed
// and the memory is still not ready. MEM_TIMEOUT=0 disables it; MEM_TIMEOUT must fit in TO_W bits.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic timeout
);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear || !req) begin
      cnt <= '0;
    end else if (!ready && cnt != {TO_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (MEM_TIMEOUT != 0) && req && !ready && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_main_controller.sv
// Moore FSM sequencing one MIPS instruction over several cycles through a shared ALU and one memory port.
// Control word is registered alongside the state; only fetch IR/PC writes and sw completion follow MEM_READY.
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  multicycle_main_controller_if.master  bus
);
  state_t     state, state_nxt;
  ctrl_t      ctrl;
  logic [1:0] cause, cause_nxt;
  logic       timeout;

  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (bus.MEM_READY) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Instruction)
          OP_W'(OPC_LW), OP_W'(OPC_SW): state_nxt = S_MEMADR;
          OP_W'(OPC_RTYPE): state_nxt = (bus.Function == OP_W'(FN_JR)) ? S_JR : S_RTYPE_EX;
          OP_W'(OPC_BEQ):  state_nxt = S_BEQ;
          OP_W'(OPC_ADDI): state_nxt = S_ADDI_EX;
          OP_W'(OPC_LUI):  state_nxt = S_LUI_EX;
          OP_W'(OPC_J):    state_nxt = S_JUMP;
          default: begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_nxt = (bus.Instruction == OP_W'(OPC_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.MEM_READY) state_nxt = S_MEMWB;
      S_MEMWR:  if (bus.MEM_READY) state_nxt = S_FETCH;
      S_RTYPE_EX: state_nxt = S_ALUWB;
      S_ADDI_EX, S_LUI_EX: state_nxt = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_IMMWB, S_JUMP, S_JR: state_nxt = S_FETCH;
      default: state_nxt = state;
    endcase
    // A stalled access that reaches the limit overrides whatever the request state would do.
    if (timeout) begin
      state_nxt = S_TRAP;
      cause_nxt = CAUSE_TIMEOUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
      ctrl  <= '0;
      cause <= CAUSE_NONE;
    end else begin
      state <= state_nxt;
      ctrl  <= state_ctrl(state_nxt);
      cause <= cause_nxt;
    end
  end

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wait_timer (
    .clk     (CLK),
    .rst_n   (RST_N),
    .req     (ctrl.mem_req),
    .ready   (bus.MEM_READY),
    .clear   (state_nxt != state),
    .timeout (timeout)
  );

  assign bus.MEM_REQ         = ctrl.mem_req;
  assign bus.IorD            = ctrl.iord;
  assign bus.DM_WRITE_ENABLE = ctrl.dm_we;
  assign bus.IRWrite         = ctrl.fetch_upd & bus.MEM_READY;
  assign bus.PCWrite         = ctrl.pc_write | (ctrl.fetch_upd & bus.MEM_READY);
  assign bus.Branch          = ctrl.branch;
  assign bus.PCSrc           = ctrl.pc_src;
  assign bus.ALUSrcA         = ctrl.alu_src_a;
  assign bus.ALUSrcB         = ctrl.alu_src_b;
  assign bus.ALUOp           = ctrl.alu_op;
  assign bus.RF_WRITE_ENABLE = ctrl.rf_we;
  assign bus.MtoRFSEL        = ctrl.m_to_rf;
  assign bus.RFDSel          = ctrl.rfd_sel;
  assign bus.INSTR_DONE      = ctrl.done | (ctrl.done_on_rdy & bus.MEM_READY);
  assign bus.TRAP            = ctrl.trap;
  assign bus.TRAP_CAUSE      = cause;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Drives random instruction streams and memory stalls; the reference expands each instruction into the
// cycle-by-cycle phase list it should take and checks the full control word every cycle.
module tb_multicycle_main_controller;

  localparam int T = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_JR    = 6'b001000;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4, P_MEMWB = 5,
                 P_MEMWR = 6, P_RTYPE = 7, P_ALUWB = 8, P_BEQ = 9, P_ADDI = 10, P_LUI = 11,
                 P_IMMWB = 12, P_JUMP = 13, P_JR = 14, P_TRAP = 15;

  typedef struct packed {
    logic       mem_req, iord, dm_we, ir_wr, pc_wr, branch;
    logic [1:0] pc_src;
    logic       src_a;
    logic [1:0] src_b, alu_op;
    logic       rf_we, mtorf, rfdsel, done, trap;
    logic [1:0] cause;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [1:0] model_cause = 2'b00;
  logic [5:0] legal_ops [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_LUI, OP_J};

  multicycle_main_controller_if #(.OP_W(6)) bus ();

  multicycle_main_controller #(
    .OP_W(6), .MEM_TIMEOUT(T), .TO_W(8)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string phase_name(input int ph);
    case (ph)
      P_IDLE: return "idle";     P_FETCH: return "fetch";   P_DECODE: return "decode";
      P_MEMADR: return "memadr"; P_MEMRD: return "memrd";   P_MEMWB: return "memwb";
      P_MEMWR: return "memwr";   P_RTYPE: return "rtype_ex"; P_ALUWB: return "aluwb";
      P_BEQ: return "beq";       P_ADDI: return "addi_ex";  P_LUI: return "lui_ex";
      P_IMMWB: return "immwb";   P_JUMP: return "jump";     P_JR: return "jr";
      default: return "trap";
    endcase
  endfunction

  function automatic bit coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = '{bus.MEM_REQ, bus.IorD, bus.DM_WRITE_ENABLE, bus.IRWrite, bus.PCWrite, bus.Branch,
          bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RF_WRITE_ENABLE, bus.MtoRFSEL,
          bus.RFDSel, bus.INSTR_DONE, bus.TRAP, bus.TRAP_CAUSE};
    return o;
  endfunction

  // Control word each phase must show, written straight from the per-state output lists.
  function automatic obs_t expect_for(input int ph, input bit rdy);
    obs_t e;
    e = '0;
    case (ph)
      P_FETCH:  begin e.mem_req = 1; e.ir_wr = rdy; e.pc_wr = rdy; e.src_b = 2'b01; end
      P_DECODE: e.src_b = 2'b11;
      P_MEMADR: begin e.src_a = 1; e.src_b = 2'b10; end
      P_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
      P_MEMWB:  begin e.rf_we = 1; e.mtorf = 1; e.done = 1; end
      P_MEMWR:  begin e.mem_req = 1; e.iord = 1; e.dm_we = 1; e.done = rdy; end
      P_RTYPE:  begin e.src_a = 1; e.alu_op = 2'b10; end
      P_ALUWB:  begin e.rf_we = 1; e.rfdsel = 1; e.done = 1; end
      P_BEQ:    begin e.src_a = 1; e.alu_op = 2'b01; e.branch = 1; e.pc_src = 2'b01; e.done = 1; end
      P_ADDI:   begin e.src_a = 1; e.src_b = 2'b10; end
      P_LUI:    begin e.src_a = 1; e.src_b = 2'b10; e.alu_op = 2'b11; end
      P_IMMWB:  begin e.rf_we = 1; e.done = 1; end
      P_JUMP:   begin e.pc_wr = 1; e.pc_src = 2'b10; e.done = 1; end
      P_JR:     begin e.pc_wr = 1; e.pc_src = 2'b11; e.done = 1; end
      P_TRAP:   begin e.trap = 1; e.cause = model_cause; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(input int ph, input bit rdy, input bit rst_v);
    @(negedge clk);
    rst_n = rst_v;
    bus.MEM_READY = rdy;
    #1;
    check_val(phase_name(ph), {12'b0, observe()}, {12'b0, expect_for(ph, rdy)});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.MEM_READY = coin();
    model_cause = 2'b00;
    cyc(P_IDLE, coin(), 1'b0);
    cyc(P_IDLE, coin(), 1'b1);
  endtask

  // wf/wm: stall cycles before MEM_READY on the fetch and on the data access.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm,
                           input bit abort_rd);
    bus.Instruction = op;
    bus.Function    = fn;
    for (int i = 0; i < wf; i++) cyc(P_FETCH, 1'b0, 1'b1);
    cyc(P_FETCH, 1'b1, 1'b1);
    cyc(P_DECODE, coin(), 1'b1);
    case (op)
      OP_LW: begin
        cyc(P_MEMADR, coin(), 1'b1);
        if (abort_rd) begin
          cyc(P_MEMRD, 1'b0, 1'b1);
          cyc(P_MEMRD, 1'b0, 1'b0);
          cyc(P_IDLE, coin(), 1'b0);
          cyc(P_IDLE, coin(), 1'b1);
          return;
        end
        for (int i = 0; i < wm; i++) cyc(P_MEMRD, 1'b0, 1'b1);
        cyc(P_MEMRD, 1'b1, 1'b1);
        cyc(P_MEMWB, coin(), 1'b1);
      end
      OP_SW: begin
        cyc(P_MEMADR, coin(), 1'b1);
        for (int i = 0; i < wm; i++) cyc(P_MEMWR, 1'b0, 1'b1);
        cyc(P_MEMWR, 1'b1, 1'b1);
      end
      OP_R: begin
        if (fn == F_JR) cyc(P_JR, coin(), 1'b1);
        else begin
          cyc(P_RTYPE, coin(), 1'b1);
          cyc(P_ALUWB, coin(), 1'b1);
        end
      end
      OP_BEQ:  cyc(P_BEQ, coin(), 1'b1);
      OP_ADDI: begin cyc(P_ADDI, coin(), 1'b1); cyc(P_IMMWB, coin(), 1'b1); end
      OP_LUI:  begin cyc(P_LUI, coin(), 1'b1); cyc(P_IMMWB, coin(), 1'b1); end
      OP_J:    cyc(P_JUMP, coin(), 1'b1);
      default: begin
        model_cause = 2'b01;
        repeat (20) cyc(P_TRAP, coin(), 1'b1);
      end
    endcase
  endtask

  // T stalled cycles are tolerated; a further not-ready cycle trips the bus timeout.
  task automatic fetch_timeout();
    for (int i = 0; i <= T; i++) cyc(P_FETCH, 1'b0, 1'b1);
    model_cause = 2'b10;
    repeat (6) cyc(P_TRAP, coin(), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int sel;
    rst_n = 1'b0;
    bus.MEM_READY = 1'b0;
    bus.Instruction = '0;
    bus.Function = '0;
    apply_reset();

    run_instr(OP_LW, 6'h00, 0, 0, 1'b0);
    run_instr(OP_SW, 6'h00, 0, 3, 1'b0);
    run_instr(OP_R, F_JR, 0, 0, 1'b0);
    run_instr(OP_BEQ, 6'h00, 0, 0, 1'b0);
    run_instr(OP_R, 6'b100000, 1, 0, 1'b0);
    run_instr(OP_ADDI, 6'h00, 0, 0, 1'b0);
    run_instr(OP_LUI, 6'h00, 2, 0, 1'b0);
    run_instr(OP_J, 6'h00, 0, 0, 1'b0);

    run_instr(OP_LW, 6'h00, 0, 0, 1'b1);
    run_instr(OP_LW, 6'h00, 0, T, 1'b0);

    run_instr(6'b111111, 6'h00, 0, 0, 1'b0);
    apply_reset();

    fetch_timeout();
    apply_reset();
    run_instr(OP_ADDI, 6'h00, T, 0, 1'b0);
    run_instr(OP_J, 6'h00, T - 1, 0, 1'b0);

    repeat (150) begin
      sel = $urandom_range(0, 19);
      fn = 6'($urandom_range(0, 63));
      if (sel == 19) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
        run_instr(op, fn, $urandom_range(0, T), 0, 1'b0);
        apply_reset();
      end else begin
        op = legal_ops[sel % 7];
        if (op == OP_R && coin()) fn = F_JR;
        run_instr(op, fn, $urandom_range(0, T), $urandom_range(0, T), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
